// File: rtl/uart_rx_periph.sv
// 8N1 UART receiver: 16x oversampled deframer that holds one byte and its
// status flags until the CPU read path acknowledges them.
module uart_rx_periph #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam int TW = $clog2(DIV);

    logic [TW-1:0] tcnt;
    logic          tick;
    logic          s1, rx_s, prev;
    logic [1:0]    state;
    logic [3:0]    scnt;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          stop_pt;

    assign tick    = (tcnt == TW'(DIV - 1));
    assign stop_pt = (state == STOP) && tick && (scnt == 4'd15);
    assign busy    = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            tcnt      <= '0;
            s1        <= 1'b1;
            rx_s      <= 1'b1;
            prev      <= 1'b1;
            state     <= IDLE;
            scnt      <= 4'd0;
            bcnt      <= 3'd0;
            shreg     <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // tick phase is free-running; start bits are not realigned to it
            tcnt <= tick ? '0 : tcnt + 1'b1;
            s1   <= UART_RX;
            rx_s <= s1;
            prev <= rx_s;

            if (rd_ack) begin
                rx_valid  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (prev && !rx_s) begin
                        scnt  <= 4'd0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt == 4'd7) begin
                            if (!rx_s) begin
                                scnt  <= 4'd0;
                                bcnt  <= 3'd0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7) state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            // later assignments here win over the rd_ack clears above
                            if (rx_s) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                if (rx_valid && !rd_ack) overrun <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx_periph.md
Name: uart_rx_periph

Overview:
- 8N1 UART receiver peripheral for the single-cycle MIPS system.
- Sits between the UART_RX board pin and the data-memory peripheral decode, and runs on sys_clk rather than the divided CPU clock.
- Oversamples the line 16x, deframes one byte at a time, and holds it with status flags until the CPU read path acknowledges it.
- Feeds the UART receive-data and status registers that the CPU reads through load instructions.

Parameters:
- CLK_FREQ, 100000000: sys_clk frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DIV, CLK_FREQ/(BAUD*16) (integer floor; 651 at defaults): sys_clk cycles per oversample tick. Must be ≥ 2.

Ports:
- sys_clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- UART_RX, input, 1: asynchronous serial line; idle level is 1.
- rd_ack, input, 1: single-cycle pulse from the peripheral decode when the CPU reads the RX data register.
- rx_data, output, 8: last correctly framed byte, LSB received first.
- rx_valid, output, 1: rx_data holds an unread byte.
- overrun, output, 1: sticky; a byte completed while rx_valid=1 and it was not being acknowledged.
- frame_err, output, 1: sticky; a stop bit was sampled as 0.
- busy, output, 1: receiver FSM is outside IDLE.

Behaviour:
- Reset (sync, takes priority over everything):
  - rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
  - FSM goes to IDLE; tick and sample counters clear.
  - Both synchronizer flops and the previous-sample register load 1.
  - Reset during a frame abandons that frame; the next falling edge is treated as a new start.
- Synchronizer: two flops, rx_s = 2nd stage. Edge detection uses rx_s and its one-cycle-delayed copy.
- Tick generator:
  - Free-running counter 0..DIV-1; tick=1 for the one cycle where the count equals DIV-1, then the counter wraps to 0.
  - Only reset clears it; it is not restarted at a start bit.
- Sample counter: 4 bits, counts ticks and wraps 15→0. Bit counter: 3 bits.
- FSM:
  - IDLE: busy=0. On a falling edge of rx_s (previous=1, current=0), clear the sample counter and go to START.
  - START: on the tick where the sample counter reaches 7 (mid-bit):
    - rx_s=0: clear the sample counter and bit counter, go to DATA.
    - rx_s=1: treat as a glitch, return to IDLE with no flags changed.
  - DATA: on the tick where the sample counter reaches 15:
    - Shift rx_s into the shift register from the MSB side, so bit 0 is received first and lands in bit 0 after 8 shifts.
    - Increment the bit counter. After the 8th bit, go to STOP.
  - STOP: on the tick where the sample counter reaches 15, sample rx_s:
    - 1: rx_data ← shift register and rx_valid ← 1. If rx_valid was already 1 and rd_ack is not asserted in that cycle, overrun ← 1 (the new byte still overwrites rx_data).
    - 0: frame_err ← 1; rx_data and rx_valid are unchanged.
    - Either way, go to IDLE. A new start needs a fresh 1→0 edge, so a break condition (line held low) produces exactly one framing error.
- Latency: rx_valid rises one cycle after the STOP sampling tick, about 9.5 bit times (152 ticks) after the start edge plus 2–3 cycles of synchronizer delay.
- rd_ack:
  - Clears rx_valid, overrun and frame_err on the next edge.
  - If a good stop completes in the same cycle, rx_valid stays 1, rx_data takes the new byte, and overrun stays 0.
  - If a framing error occurs in the same cycle, frame_err ends at 1.
  - rd_ack while rx_valid=0 has no effect apart from clearing the sticky flags.
- The FSM ignores UART_RX except at the sample points described above.

Test Plan (CLK_FREQ=1600000, BAUD=10000 → DIV=10, bit time = 160 cycles):
1. Send 0xA5 (8N1) with no ack → rx_data=0xA5 and rx_valid=1 between 1515 and 1535 cycles after the falling edge; overrun=0, frame_err=0; busy=0 after the stop bit.
2. Drive a 40-cycle low glitch on an idle line → busy pulses for about 80 cycles, then returns to 0; rx_valid, frame_err and rx_data stay 0.
3. Send 0x3C then 0xC3 back-to-back with no ack → rx_data=0xC3, rx_valid=1, overrun=1; then one rd_ack pulse → rx_valid=0 and overrun=0 on the next cycle.
4. Send 0x55 with the stop bit driven 0 → frame_err=1, rx_valid=0, rx_data unchanged (0x00 after reset); the line held low afterward raises no second error.
5. Assert reset for one cycle during data bit 3 of 0x7E, then send 0x81 → all outputs 0 after reset; 0x81 is received correctly with no flags set.
6. Pulse rd_ack exactly on the STOP-sample cycle of 0x0F while rx_valid=1 holding 0x11 → rx_data=0x0F, rx_valid=1, overrun=0.
